// File: rtl/sram_stream_reader.sv
// Streams len words from a single-port SRAM (1-cycle read latency) onto a valid/ready port.
// First out_valid two edges after start; a 3-entry FIFO plus credit gating absorbs consumer stalls losslessly.
module sram_stream_reader #(
  parameter int DW = 128,
  parameter int AW = 11
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  input  logic [DW-1:0] sram_q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_RUN    = 1'b1;
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [0:0]    state;
  logic [AW-1:0] addr;
  logic [AW-1:0] a_hold;
  logic [AW:0]   issue_cnt;
  logic [AW:0]   recv_cnt;
  logic          inflight;
  logic          zero_done;

  logic [DW-1:0] fifo_mem [3];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [1:0]    fifo_count;

  logic          issue;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [2:0]    credit_use;

  // Issue is a function of registered state only, so out_ready never reaches the SRAM pins.
  assign credit_use = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue      = (state == S_RUN) && (issue_cnt != '0) && (credit_use < 3'd3);
  assign push       = inflight;
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = fifo_mem[rd_ptr];
  assign pop        = out_valid && out_ready;
  assign last_pop   = (state == S_RUN) && pop && (recv_cnt == CNT_ONE);
  assign done       = last_pop || zero_done;
  assign busy       = (state == S_RUN);
  assign sram_cen   = ~issue;
  assign sram_wen   = 1'b1;
  assign sram_a     = issue ? addr : a_hold;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      addr      <= '0;
      a_hold    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      inflight  <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr      <= start_addr;
              issue_cnt <= len;
              recv_cnt  <= len;
              state     <= S_RUN;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        default: begin
          if (issue) begin
            addr      <= addr + ADDR_ONE;
            a_hold    <= addr;
            issue_cnt <= issue_cnt - CNT_ONE;
          end
          if (pop) begin
            recv_cnt <= recv_cnt - CNT_ONE;
          end
          if (last_pop) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 3; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sram_q;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Read-side controller for the 128-bit x 2048-word single-port SRAM macro. It accepts a start address and word count, issues back-to-back SRAM reads, and absorbs the SRAM's one-cycle registered-address read latency. Returned words go out on a valid/ready stream, and consumer back-pressure never loses or duplicates a word. It sits between an SRAM instance and downstream consumers (L0/IFIFO loaders, output dump).

## Interface
- DW, 128, data word width (matches SRAM D/Q)
- AW, 11, SRAM address width (2^AW = 2048 words)
- CLK  in  1  clock; all state updates on posedge
- RESET_N  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only when busy=0
- start_addr  in  AW  first word address
- len  in  AW+1  number of words to read (0..4095)
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the last word is accepted downstream
- sram_cen  out  1  SRAM chip enable, active low
- sram_wen  out  1  SRAM write enable, active low; tied 1 (read only)
- sram_a  out  AW  SRAM address
- sram_q  in  DW  SRAM read data
- out_data  out  DW  stream data (head of output FIFO)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer

## Operation
- **State IDLE**
  - start=1 with len!=0: load addr=start_addr, issue_cnt=len, recv_cnt=len; go to RUN; busy=1 from next cycle.
  - start=1 with len=0: no SRAM access; done pulses the following cycle; stay IDLE.
- **State RUN**
  - Each cycle with issue_cnt!=0 and (fifo_count + inflight) < 3, drive sram_cen=0 and sram_a=addr.
  - On that edge: addr increments modulo 2^AW (2047 -> 0), issue_cnt decrements, inflight<=1.
  - Otherwise sram_cen=1. sram_a holds its last value.
- **Capture**
  - When inflight=1, sram_q is valid this cycle and is pushed into the 3-entry output FIFO at the edge.
  - inflight clears unless a new read issues on the same cycle.
- **Output FIFO**
  - 3 entries, in order. out_valid = (fifo_count != 0); out_data = head entry.
  - Pop on out_valid & out_ready. Push and pop on the same edge keeps count unchanged.
  - The credit rule guarantees no overflow.
- **Completion**
  - Pop of the word where recv_cnt reaches 0: done=1 for that cycle, busy=0 and state=IDLE from the next edge.
- start while busy=1 is ignored; no queuing.
- No combinational path from out_ready to sram_cen/sram_a. Issue depends only on registered state.
- len counts wrap reads: len > 2048 re-reads from start_addr after wrap.

## Timing
- **Reset values**
  - busy=0, done=0, sram_cen=1, sram_wen=1, sram_a=0, out_valid=0, out_data=0
  - FIFO empty, inflight=0, state=IDLE
- **Reset mid-transfer:** all of the above apply immediately (async). Any pending words are discarded. No spurious sram_cen=0 after reset deassertion.
- **Latency:** start sampled at edge k.
  - First sram_cen=0 in cycle k..k+1.
  - sram_q valid after edge k+1.
  - out_valid=1 after edge k+2.
- **Throughput:** with out_ready held 1, one word per cycle. len=N completes with done at the cycle after edge k+N+1.
- **Back-pressure:** with out_ready=0 the FIFO fills to 3 and issue stops. Resuming out_ready restores one word per cycle without a bubble after the first pop.
- out_data/out_valid stay stable while out_valid=1 and out_ready=0.

## Test plan
- **Single word:** preload mem[5]=0xA5..A5, start_addr=5, len=1, out_ready=1.
  - Exactly one sram_cen=0 cycle with sram_a=5.
  - out_valid one cycle with 0xA5..A5; done pulses on that cycle; busy low next cycle.
- **Burst:** mem[i]=i, start_addr=100, len=8, out_ready=1.
  - Words 100..107 in order on 8 consecutive cycles.
  - First out_valid 2 cycles after the start edge; no gaps.
- **Back-pressure:** same burst with out_ready toggled 1,0,0,1 pseudo-randomly.
  - All 8 words delivered once, in order, data stable during stalls.
  - At most 3 reads outstanding beyond the last accepted word.
- **Wrap:** start_addr=2046, len=4.
  - sram_a sequence 2046, 2047, 0, 1; data mem[2046], mem[2047], mem[0], mem[1].
- **Corner controls:**
  - len=0: done pulse, no sram_cen=0.
  - start asserted mid-burst with different start_addr: ignored, original burst completes unchanged.
- **Reset mid-burst:** assert RESET_N=0 after 3 words delivered of len=8.
  - Outputs take reset values asynchronously.
  - A new start after release (addr=0, len=2) returns mem[0], mem[1] only.
